fixed_div_unit: RTL and testbench

- Iterative signed fixed-point divider. It is the responder side of the divisor/dividend valid-stream interface that the fixed-point math blocks (lerp, normalise, reciprocal users) drive.
- Computes (dividend << FRAC) / divisor, one quotient bit per cycle.
- Output side is a valid/ready channel.
- Saturates on overflow and flags divide-by-zero, so no IP core is needed.

---
 rtl/fixed_div_unit.sv | 153 +++++++++++++++
 tb/tb_fixed_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div_unit.sv
// Iterative signed fixed-point divider: (dividend << FRAC) / divisor, one quotient
// bit per cycle, saturating on overflow and flagging divide-by-zero.
module fixed_div_unit #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             s_ready,
    input  logic             s_divisor_valid,
    input  logic [WIDTH-1:0] s_divisor_data,
    input  logic             s_dividend_valid,
    input  logic [WIDTH-1:0] s_dividend_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_div0,
    output logic             m_ovf
);
    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [NW-1:0]    HALF    = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic             s_ready_q;
    logic             m_valid_q;
    logic             m_div0_q;
    logic             m_ovf_q;
    logic [WIDTH-1:0] m_data_q;
    logic             sign_q;
    logic             div0_q;
    logic             fin_q;
    logic [NW-1:0]    num_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;

    logic             accept_d;
    logic [WIDTH-1:0] abs_dvd_d;
    logic [WIDTH-1:0] abs_dvs_d;
    logic [WIDTH:0]   trial_d;
    logic             q_bit_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] res_data_d;
    logic             res_ovf_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        accept_d   = s_ready_q && s_divisor_valid && s_dividend_valid;
        abs_dvd_d  = s_dividend_data[WIDTH-1] ? -s_dividend_data : s_dividend_data;
        abs_dvs_d  = s_divisor_data[WIDTH-1]  ? -s_divisor_data  : s_divisor_data;
        trial_d    = {rem_q, num_q[NW-1]};
        q_bit_d    = trial_d >= {1'b0, den_q};
        rem_d      = q_bit_d ? WIDTH'(trial_d - {1'b0, den_q}) : trial_d[WIDTH-1:0];
        res_data_d = num_q[WIDTH-1:0];
        res_ovf_d  = 1'b0;

        // num_q holds the quotient magnitude once the iterations finish; for div0 it
        // still holds the shifted dividend magnitude, so zero there means zero dividend.
        if (div0_q) begin
            if (sign_q)
                res_data_d = NEG_MIN;
            else if (num_q == '0)
                res_data_d = '0;
            else
                res_data_d = POS_MAX;
        end else if (!sign_q) begin
            if (num_q >= HALF) begin
                res_data_d = POS_MAX;
                res_ovf_d  = 1'b1;
            end
        end else begin
            if (num_q > HALF) begin
                res_data_d = NEG_MIN;
                res_ovf_d  = 1'b1;
            end else begin
                res_data_d = -num_q[WIDTH-1:0];
            end
        end
    end

    // NOTE: all state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_div0_q  <= 1'b0;
            m_ovf_q   <= 1'b0;
            m_data_q  <= '0;
            sign_q    <= 1'b0;
            div0_q    <= 1'b0;
            fin_q     <= 1'b0;
            num_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (accept_d) begin
                        state_q   <= CALC;
                        s_ready_q <= 1'b0;
                        sign_q    <= s_dividend_data[WIDTH-1] ^ s_divisor_data[WIDTH-1];
                        num_q     <= {abs_dvd_d, {FRAC{1'b0}}};
                        den_q     <= abs_dvs_d;
                        rem_q     <= '0;
                        cnt_q     <= CW'(NW - 1);
                        div0_q    <= (s_divisor_data == '0);
                        fin_q     <= (s_divisor_data == '0);
                    end
                end
                CALC: begin
                    if (fin_q) begin
                        state_q   <= DONE;
                        m_valid_q <= 1'b1;
                        m_data_q  <= res_data_d;
                        m_div0_q  <= div0_q;
                        m_ovf_q   <= res_ovf_d;
                    end else begin
                        rem_q <= rem_d;
                        num_q <= {num_q[NW-2:0], q_bit_d};
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0)
                            fin_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        m_div0_q  <= 1'b0;
                        m_ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_div0  = m_div0_q;
    assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_fixed_div_unit.sv
// Bench for fixed_div_unit: directed cases from the datasheet plus randomized operand
// pairs compared against a plain-arithmetic model of truncation, saturation and div0.
module tb_fixed_div_unit;
    localparam int W = 32;
    localparam int F = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         s_ready;
    logic         s_divisor_valid = 1'b0;
    logic [W-1:0] s_divisor_data = '0;
    logic         s_dividend_valid = 1'b0;
    logic [W-1:0] s_dividend_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_div0;
    logic         m_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_div_unit #(.WIDTH(W), .FRAC(F)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .s_ready          (s_ready),
        .s_divisor_valid  (s_divisor_valid),
        .s_divisor_data   (s_divisor_data),
        .s_dividend_valid (s_dividend_valid),
        .s_dividend_data  (s_dividend_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_div0           (m_div0),
        .m_ovf            (m_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed quotient with truncation toward zero, then clamp.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output logic z, output logic o);
        longint sa;
        longint sb;
        longint q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        z = 1'b0;
        o = 1'b0;
        if (sb == 0) begin
            z = 1'b1;
            d = (sa > 0) ? 32'h7FFF_FFFF : (sa < 0) ? 32'h8000_0000 : 32'h0;
        end else begin
            q = (sa * 65536) / sb;
            if (q > 64'sd2147483647) begin
                d = 32'h7FFF_FFFF;
                o = 1'b1;
            end else if (q < -64'sd2147483648) begin
                d = 32'h8000_0000;
                o = 1'b1;
            end else begin
                d = q[31:0];
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("s_ready_timeout", 64'd0, 64'd1);
        s_dividend_data  = a;
        s_divisor_data   = b;
        s_dividend_valid = 1'b1;
        s_divisor_valid  = 1'b1;
        @(negedge clk);
        s_dividend_valid = 1'b0;
        s_divisor_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit offer);
        logic [31:0] ed;
        logic        ez;
        logic        eo;
        int          lat;
        ref_div(a, b, ed, ez, eo);
        m_ready = (hold == 0);
        start_op(a, b);
        wait_valid(lat);
        check("latency", lat, ez ? 1 : 49);
        check("m_data", m_data, ed);
        check("m_div0", m_div0, ez);
        check("m_ovf", m_ovf, eo);
        if (hold > 0) begin
            if (offer) begin
                s_dividend_data  = $urandom;
                s_divisor_data   = $urandom;
                s_dividend_valid = 1'b1;
                s_divisor_valid  = 1'b1;
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, ed);
                check("hold_flags", {m_div0, m_ovf}, {ez, eo});
                check("hold_s_ready", s_ready, 0);
            end
            m_ready = 1'b1;
        end
        @(negedge clk);
        s_dividend_valid = 1'b0;
        s_divisor_valid  = 1'b0;
        m_ready = 1'b0;
        check("post_valid", m_valid, 0);
        check("post_s_ready", s_ready, 1);
        check("post_flags", {m_div0, m_ovf}, 2'b00);
        check("post_data_kept", m_data, ed);
        if (offer) begin
            @(negedge clk);
            check("offer_not_taken", s_ready, 1);
            check("offer_no_result", m_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        #2;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_flags", {m_div0, m_ovf}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Basic and sign/truncation cases
        run_op(32'h0003_0000, 32'h0002_0000, 0, 1'b0);
        check("basic_value", m_data, 32'h0001_8000);
        run_op(32'hFFFD_0000, 32'h0002_0000, 0, 1'b0);
        check("neg_value", m_data, 32'hFFFE_8000);
        run_op(32'h0001_0000, 32'h0003_0000, 0, 1'b0);
        check("third_value", m_data, 32'h0000_5555);
        run_op(32'hFFFF_0000, 32'hFFFD_0000, 0, 1'b0);
        check("negneg_value", m_data, 32'h0000_5555);

        // Divide-by-zero and overflow boundaries
        run_op(32'h0005_0000, 32'h0000_0000, 0, 1'b0);
        check("div0_pos_value", m_data, 32'h7FFF_FFFF);
        run_op(32'hFFFB_0000, 32'h0000_0000, 0, 1'b0);
        check("div0_neg_value", m_data, 32'h8000_0000);
        run_op(32'h0000_0000, 32'h0000_0000, 0, 1'b0);
        run_op(32'h7FFF_0000, 32'h0000_0001, 0, 1'b0);
        check("ovf_value", m_data, 32'h7FFF_FFFF);
        run_op(32'h8000_0000, 32'h0001_0000, 0, 1'b0);
        check("min_value", m_data, 32'h8000_0000);
        run_op(32'h8000_0000, 32'h8000_0000, 2, 1'b0);

        // A lone dividend valid must not be accepted
        s_dividend_data  = 32'h0004_0000;
        s_dividend_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("single_s_ready", s_ready, 1);
            check("single_m_valid", m_valid, 0);
        end
        s_dividend_valid = 1'b0;

        // Consumer stall with a new pair offered during the hold
        run_op(32'h0003_0000, 32'h0002_0000, 10, 1'b1);

        // Reset in the middle of a calculation
        m_ready = 1'b1;
        start_op(32'h0003_0000, 32'h0002_0000);
        repeat (20) @(negedge clk);
        check("mid_calc_s_ready", s_ready, 0);
        check("mid_calc_m_valid", m_valid, 0);
        resetn = 1'b0;
        #1;
        check("async_rst_s_ready", s_ready, 0);
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_m_data", m_data, 0);
        check("async_rst_flags", {m_div0, m_ovf}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op(32'h0003_0000, 32'h0002_0000, 0, 1'b0);
        check("after_rst_value", m_data, 32'h0001_8000);

        // Randomized operand pairs with random consumer stalls
        for (int k = 0; k < 1000; k++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 15) == 0) b = 32'h0;
            if ($urandom_range(0, 31) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 31) == 0) b = 32'h8000_0000;
            run_op(a, b, $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
